// File: rtl/hkspi_pkg.sv
// Housekeeping SPI slave shared definitions.
//   hkspi_state_e : controller FSM states
//   CMD_*         : bit positions / mask inside the command byte
//   cmd_valid()   : true when a command byte selects a real register transfer
package hkspi_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    IGNORE = 3'd4
  } hkspi_state_e;

  localparam int         CMD_WR_BIT   = 7;
  localparam int         CMD_RD_BIT   = 6;
  localparam int         CMD_N_MSB    = 5;
  localparam int         CMD_N_LSB    = 3;
  localparam logic [2:0] CMD_RSV_MASK = 3'b111;

  // 0x00 and any command with reserved/pass-thru bits set are not handled here.
  function automatic logic cmd_valid(input logic [7:0] cmd);
    return (cmd != 8'h00) && ((cmd[2:0] & CMD_RSV_MASK) == 3'b000);
  endfunction

endpackage

// File: rtl/hkspi_sync.sv
// Single-bit input synchronizer with edge detection.
//   clock, reset : system clock, synchronous active-high reset
//   d            : asynchronous input pin
//   q            : synchronized level (RST_VAL while in reset)
//   rise, fall   : one-cycle pulses on synchronized edges
// Edges are suppressed until the chain and the history flop hold real pin
// samples, so the reset value of the chain never produces a false edge.
module hkspi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stage_q, stage_d;
  logic                   prev_q, prev_d;
  logic [SYNC_STAGES:0]   vld_q, vld_d;

  always_comb begin
    stage_d = {stage_q[SYNC_STAGES-2:0], d};
    prev_d  = stage_q[SYNC_STAGES-1];
    vld_d   = {vld_q[SYNC_STAGES-1:0], 1'b1};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stage_q <= {SYNC_STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
      vld_q   <= '0;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
      vld_q   <= vld_d;
    end
  end

  assign q    = stage_q[SYNC_STAGES-1];
  assign rise = vld_q[SYNC_STAGES] &  q & ~prev_q;
  assign fall = vld_q[SYNC_STAGES] & ~q &  prev_q;

endmodule

// File: rtl/hkspi_slave_ctrl.sv
// Housekeeping SPI slave front-end (mode 0, MSB first), system clock domain.
//   clock, reset        : system clock, synchronous active-high reset
//   spi_sck/csb/sdi     : asynchronous SPI pins from the pads
//   spi_sdo, spi_sdo_oe : slave-out data and its enable
//   reg_addr            : register address (auto-increments per data byte)
//   reg_wdata, reg_we   : write data with one-cycle write strobe
//   reg_rd, reg_rdata   : one-cycle read strobe; data returns the next cycle
//   busy                : synchronized chip-select active
// Handshake: reg_we and reg_rd are single-cycle strobes qualified by the
// reg_addr presented in the same cycle; reg_rdata is sampled exactly one
// cycle after reg_rd with no back-pressure. The two strobes never coincide.
module hkspi_slave_ctrl
  import hkspi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_csb,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdo_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  logic sck_unused_lvl, sck_rise, sck_fall;
  logic csb_s, csb_rise, csb_fall;
  logic sdi_s, sdi_unused_rise, sdi_unused_fall;

  hkspi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clock(clock), .reset(reset), .d(spi_sck),
    .q(sck_unused_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  // Chip select idles high, so its chain resets high: busy stays 0 in reset.
  hkspi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
    .clock(clock), .reset(reset), .d(spi_csb),
    .q(csb_s), .rise(csb_rise), .fall(csb_fall)
  );

  hkspi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clock(clock), .reset(reset), .d(spi_sdi),
    .q(sdi_s), .rise(sdi_unused_rise), .fall(sdi_unused_fall)
  );

  hkspi_state_e      state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              rd_q, rd_d;
  logic              rd_dly_q, rd_dly_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic              cmd_rd_q, cmd_rd_d;
  logic [2:0]        cmd_n_q, cmd_n_d;
  logic              inc_pend_q, inc_pend_d;
  logic              pend_rd_q, pend_rd_d;

  logic [7:0] byte_in;
  logic [2:0] cnt_next;
  logic       last_byte;

  always_comb begin
    byte_in   = {rx_q, sdi_s};
    cnt_next  = byte_cnt_q + 3'd1;
    last_byte = (cmd_n_q != 3'd0) && (cnt_next == cmd_n_q);

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    rd_d       = 1'b0;
    rd_dly_d   = rd_q;
    cmd_wr_d   = cmd_wr_q;
    cmd_rd_d   = cmd_rd_q;
    cmd_n_d    = cmd_n_q;
    inc_pend_d = 1'b0;
    pend_rd_d  = 1'b0;

    // After a write strobe the address advances one cycle later, and the
    // read for the next byte (if any) goes out with the advanced address.
    if (inc_pend_q) begin
      addr_d = addr_q + ADDR_W'(1);
      rd_d   = pend_rd_q;
    end

    // Load read data the cycle after reg_rd. On SCK fall shift the next bit
    // out, except the fall right after a byte boundary (bit_cnt wrapped to
    // 0): that one must leave the freshly loaded MSB on the pin.
    if (rd_dly_q) begin
      tx_d = reg_rdata;
    end else if (sck_fall && (state_q == DATA) && (bit_cnt_q != 3'd0)) begin
      tx_d = {tx_q[6:0], 1'b0};
    end

    case (state_q)
      IDLE: begin
        if (csb_fall) begin
          state_d    = CMD;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 3'd0;
          rx_d       = 7'd0;
        end
      end
      default: begin
        if (sck_rise) begin
          rx_d      = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            case (state_q)
              CMD: begin
                cmd_wr_d = byte_in[CMD_WR_BIT];
                cmd_rd_d = byte_in[CMD_RD_BIT];
                cmd_n_d  = byte_in[CMD_N_MSB:CMD_N_LSB];
                state_d  = cmd_valid(byte_in) ? ADDR : IGNORE;
              end
              ADDR: begin
                addr_d  = ADDR_W'(byte_in);
                rd_d    = cmd_rd_q;
                state_d = DATA;
              end
              DATA: begin
                byte_cnt_d = cnt_next;
                if (cmd_wr_q) begin
                  we_d       = 1'b1;
                  wdata_d    = byte_in;
                  inc_pend_d = 1'b1;
                  pend_rd_d  = cmd_rd_q && !last_byte;
                end else begin
                  addr_d = addr_q + ADDR_W'(1);
                  rd_d   = cmd_rd_q && !last_byte;
                end
                if (last_byte) begin
                  state_d = IGNORE;
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase

    // Chip select release ends the transfer from any state; a partial byte
    // is simply dropped.
    if (csb_rise) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 3'd0;
      rx_q       <= 7'd0;
      tx_q       <= 8'd0;
      addr_q     <= '0;
      wdata_q    <= 8'd0;
      we_q       <= 1'b0;
      rd_q       <= 1'b0;
      rd_dly_q   <= 1'b0;
      cmd_wr_q   <= 1'b0;
      cmd_rd_q   <= 1'b0;
      cmd_n_q    <= 3'd0;
      inc_pend_q <= 1'b0;
      pend_rd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      rd_dly_q   <= rd_dly_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_rd_q   <= cmd_rd_d;
      cmd_n_q    <= cmd_n_d;
      inc_pend_q <= inc_pend_d;
      pend_rd_q  <= pend_rd_d;
    end
  end

  assign spi_sdo_oe = (state_q == DATA) && cmd_rd_q;
  assign spi_sdo    = spi_sdo_oe & tx_q[7];
  assign reg_addr   = addr_q;
  assign reg_wdata  = wdata_q;
  assign reg_we     = we_q;
  assign reg_rd     = rd_q;
  assign busy       = ~csb_s;

endmodule
